// File: rtl/cast_credit_source.sv
// Credit-based flit transmitter for the cast network: emits num_pkts packets of
// PKT_LEN flits, one flit per held credit, and reports when every credit is back.
module cast_credit_source #(
  parameter int unsigned DW           = 32,
  parameter int unsigned BUFFER_ALLOC = 4,
  parameter int unsigned CRED_W       = $clog2(BUFFER_ALLOC) + 1,
  parameter int unsigned PKT_LEN      = 4,
  parameter logic [9:0]  STREAM_ID    = 10'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_pkts,
  output logic              valid_o,
  output logic [DW-1:0]     data_o,
  input  logic              ready_i,
  input  logic              credit_upd,
  output logic              busy,
  output logic              done,
  output logic [CRED_W-1:0] credit_cnt,
  output logic              credit_err
);

  localparam int unsigned SEQ_W = DW - 2;
  localparam int unsigned IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_LEN - 1);
  localparam logic [CRED_W-1:0] FULL_CRED = CRED_W'(BUFFER_ALLOC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CRED_W-1:0] cred_q, cred_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       pkt_q, pkt_d;
  logic [15:0]       npkts_q, npkts_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xfer;
  logic              last_flit;

  // Flit image for a given position within the packet and run-global sequence.
  function automatic logic [DW-1:0] make_flit(input logic [IDX_W-1:0] idx,
                                              input logic [SEQ_W-1:0] seq);
    logic [DW-1:0] f;
    f = '0;
    if (idx == '0) begin
      f[DW-1:DW-2] = 2'b01;
      f[9:0]       = STREAM_ID;
    end else begin
      f[DW-1:DW-2] = (idx == LAST_IDX) ? 2'b10 : 2'b00;
      f[SEQ_W-1:0] = seq;
    end
    return f;
  endfunction

  always_comb begin
    state_d   = state_q;
    cred_d    = cred_q;
    err_d     = err_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    npkts_d   = npkts_q;
    seq_d     = seq_q;
    data_d    = data_q;
    xfer      = valid_q & ready_i;
    last_flit = (idx_q == LAST_IDX) && ((pkt_q + 16'd1) == npkts_q);

    // Credit accounting runs in every state; a simultaneous take and return cancel.
    case ({xfer, credit_upd})
      2'b10: cred_d = cred_q - CRED_W'(1);
      2'b01: begin
        if (cred_q == FULL_CRED) err_d = 1'b1;
        else                     cred_d = cred_q + CRED_W'(1);
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          npkts_d = num_pkts;
          idx_d   = '0;
          pkt_d   = '0;
          seq_d   = '0;
          state_d = (num_pkts != 16'd0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          seq_d = seq_q + SEQ_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            pkt_d = pkt_q + 16'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (last_flit) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cred_d == FULL_CRED) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state.
    if (state_d == ST_SEND) data_d = make_flit(idx_d, seq_d);
    valid_d = (state_d == ST_SEND) && (cred_d != '0);
    busy_d  = (state_d == ST_SEND) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cred_q  <= FULL_CRED;
      err_q   <= 1'b0;
      idx_q   <= '0;
      pkt_q   <= '0;
      npkts_q <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      npkts_q <= npkts_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign credit_cnt = cred_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_cast_credit_source.sv
// Directed bench for cast_credit_source: DW=16, four credits, 4-flit packets, stream 0x2A5.
module tb_cast_credit_source;

  localparam int unsigned DW     = 16;
  localparam int unsigned CRED_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       num_pkts;
  logic              valid_o;
  logic [DW-1:0]     data_o;
  logic              ready_i;
  logic              credit_upd;
  logic              busy;
  logic              done;
  logic [CRED_W-1:0] credit_cnt;
  logic              credit_err;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] HEAD = 16'h42A5;

  cast_credit_source #(
    .DW(DW), .BUFFER_ALLOC(4), .CRED_W(CRED_W), .PKT_LEN(4), .STREAM_ID(10'h2A5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .credit_upd(credit_upd), .busy(busy), .done(done),
    .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; credit_upd = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] flits[$];
  logic [15:0] exp2[8];
  int          done_cnt;
  logic        xfer_now;

  initial begin
    rst = 1'b1; start = 1'b0; num_pkts = 16'd0; ready_i = 1'b0; credit_upd = 1'b0;
    exp2 = '{16'h42A5, 16'h0001, 16'h0002, 16'h8003, 16'h42A5, 16'h0005, 16'h0006, 16'h8007};

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_cred", 32'(credit_cnt), 32'd4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);

    // Test 1: no credit returns, run stalls after four flits
    start = 1'b1; num_pkts = 16'd2; ready_i = 1'b1;
    tick(); start = 1'b0;
    chk("t1_head", 32'(data_o), 32'(HEAD));
    chk("t1_valid0", 32'(valid_o), 32'd1);
    tick(); chk("t1_b1", 32'(data_o), 32'h0001); chk("t1_c3", 32'(credit_cnt), 32'd3);
    tick(); chk("t1_b2", 32'(data_o), 32'h0002); chk("t1_c2", 32'(credit_cnt), 32'd2);
    tick(); chk("t1_tail", 32'(data_o), 32'h8003); chk("t1_c1", 32'(credit_cnt), 32'd1);
    tick(); chk("t1_stall_valid", 32'(valid_o), 32'd0); chk("t1_c0", 32'(credit_cnt), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    start = 1'b1; num_pkts = 16'd5;
    tick(); start = 1'b0;
    tick();
    chk("t1_still_stall", 32'(valid_o), 32'd0);
    chk("t1_still_c0", 32'(credit_cnt), 32'd0);
    chk("t1_still_busy", 32'(busy), 32'd1);

    // Test 2: credit returned one cycle after each transfer
    do_reset();
    flits.delete(); done_cnt = 0;
    start = 1'b1; num_pkts = 16'd2; ready_i = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      xfer_now = valid_o & ready_i;
      if (xfer_now) flits.push_back(data_o);
      tick();
      credit_upd = xfer_now;
      if (done) begin
        done_cnt++;
        chk("t2_done_cred", 32'(credit_cnt), 32'd4);
      end
    end
    credit_upd = 1'b0;
    chk("t2_nflits", 32'(flits.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < flits.size()) chk($sformatf("t2_flit%0d", i), 32'(flits[i]), 32'(exp2[i]));
    chk("t2_done_once", 32'(done_cnt), 32'd1);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // Test 3: back-pressure holds data and credits
    do_reset();
    start = 1'b1; num_pkts = 16'd1; ready_i = 1'b1;
    tick(); start = 1'b0;
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_valid", 32'(valid_o), 32'd1);
      chk("t3_data", 32'(data_o), 32'h0001);
      chk("t3_cred", 32'(credit_cnt), 32'd3);
    end
    ready_i = 1'b1;
    tick(); chk("t3_resume", 32'(data_o), 32'h0002);

    // Test 4: credit exhaustion, return at zero, simultaneous take and return
    do_reset();
    start = 1'b1; num_pkts = 16'd2; ready_i = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    tick();
    chk("t4_zero", 32'(credit_cnt), 32'd0);
    chk("t4_novalid", 32'(valid_o), 32'd0);
    credit_upd = 1'b1; ready_i = 1'b0;
    tick();
    chk("t4_c1", 32'(credit_cnt), 32'd1);
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_head", 32'(data_o), 32'(HEAD));
    ready_i = 1'b1;
    tick();
    chk("t4_simul_c1", 32'(credit_cnt), 32'd1);
    chk("t4_simul_data", 32'(data_o), 32'h0005);
    credit_upd = 1'b0;
    tick();
    chk("t4_back0", 32'(credit_cnt), 32'd0);
    chk("t4_stop", 32'(valid_o), 32'd0);
    chk("t4_next", 32'(data_o), 32'h0006);

    // Test 5: extra credit at full count
    do_reset();
    credit_upd = 1'b1;
    tick(); credit_upd = 1'b0;
    chk("t5_err", 32'(credit_err), 32'd1);
    chk("t5_sat", 32'(credit_cnt), 32'd4);
    tick();
    chk("t5_sticky", 32'(credit_err), 32'd1);
    do_reset();
    chk("t5_cleared", 32'(credit_err), 32'd0);

    // Empty run goes straight to done
    start = 1'b1; num_pkts = 16'd0;
    tick(); start = 1'b0;
    chk("e_done", 32'(done), 32'd1);
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_valid", 32'(valid_o), 32'd0);
    tick();
    chk("e_done_pulse", 32'(done), 32'd0);

    // Test 6: reset mid-packet aborts and restarts cleanly
    do_reset();
    start = 1'b1; num_pkts = 16'd2; ready_i = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_cred", 32'(credit_cnt), 32'd4);
    chk("t6_busy", 32'(busy), 32'd0);
    start = 1'b1; num_pkts = 16'd1;
    tick(); start = 1'b0;
    chk("t6_head", 32'(data_o), 32'(HEAD));
    tick();
    chk("t6_seq1", 32'(data_o), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
